aximm_burst_wr_ctrl: RTL and testbench

AXI4 write-master burst scheduler for the `aximm_test2` video path. It takes a destination address, byte count and repeat count from the control slave. It drains the pixel FIFO into `m_axi_mm_video` as length-limited, 4 KB-safe INCR bursts, tracks outstanding write responses, and reports completion through the ap_ctrl handshake.

---
 rtl/aximm_test2_pkg.sv | 23 ++
 rtl/aximm_burst_wr_ctrl_if.sv | 45 ++++
 rtl/burst_len_calc.sv | 34 +++
 rtl/aximm_burst_wr_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_aximm_burst_wr_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aximm_test2_pkg.sv
// Shared definitions for the aximm_test2 burst write controller.
// Holds the AXI burst/response encodings, the 4 KB boundary constant, the controller FSM
// state type and a helper that turns a data width into log2(bytes per beat).
package aximm_test2_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // AXI bursts must not cross this address boundary
    localparam int unsigned BOUNDARY_4K = 4096;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StDrain
    } state_e;

    function automatic int unsigned data_bytes_log2(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/aximm_burst_wr_ctrl_if.sv
// AXI4 write-only master bus (AW, W, B channels) used by aximm_burst_wr_ctrl.
// master modport: driven by the controller; slave modport: driven by the memory side.
// Parameters: ADDR_WIDTH, DATA_WIDTH (bits, power of two >= 8), ID_WIDTH.
interface aximm_burst_wr_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = 1
);
    logic                    aw_valid;
    logic                    aw_ready;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [ID_WIDTH-1:0]     aw_id;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;

    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;

    logic                    b_valid;
    logic                    b_ready;
    logic [1:0]              b_resp;
    logic [ID_WIDTH-1:0]     b_id;

    modport master (
        output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_resp, b_id,
        output b_ready
    );

    modport slave (
        input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_resp, b_id,
        input  b_ready
    );
endinterface

// File: rtl/burst_len_calc.sv
// Combinational burst sizing: beats = min(remaining, MAX_BURST, beats left before the next
// 4 KB boundary), reported as an AXI LEN value (beats - 1).
// Ports: remaining (beats left in the pass, must be >= 1 when used), addr_lo (low 12 address
// bits, beat aligned), len (AXI AWLEN).
module burst_len_calc
    import aximm_test2_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic [31:0] remaining,
    input  logic [11:0] addr_lo,
    output logic [7:0]  len
);
    localparam int unsigned BYTES_LOG2 = data_bytes_log2(DATA_WIDTH);

    logic [12:0] room_bytes;
    logic [12:0] room_beats;
    logic [31:0] beats;

    always_comb begin
        room_bytes = 13'(BOUNDARY_4K) - {1'b0, addr_lo};
        // Address is beat aligned, so room is always at least one beat
        room_beats = room_bytes >> BYTES_LOG2;
        beats      = remaining;
        if (beats > 32'(MAX_BURST)) begin
            beats = 32'(MAX_BURST);
        end
        if (beats > {19'd0, room_beats}) begin
            beats = {19'd0, room_beats};
        end
        len = 8'(beats - 32'd1);
    end
endmodule

// File: rtl/aximm_burst_wr_ctrl.sv
// AXI4 write-master burst scheduler: drains an FWFT pixel FIFO into length-limited, 4 KB-safe
// INCR bursts, repeating the same region `times` times, with ap_ctrl start/ready/done/idle.
// Ports: ap_clk, ap_rst (sync, active high), ap_start/ap_ready/ap_done/ap_idle, dst_addr, size
// (bytes per pass), times (pass count), fifo_rd_en/fifo_rd_data/fifo_empty, m_axi_mm_video
// (AXI write master), err (only with AXIMM_BURST_WR_CTRL_BRESP_CHECK_EN defined: sticky
// non-OKAY BRESP flag, cleared on ap_ready).
module aximm_burst_wr_ctrl
    import aximm_test2_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned ID_WIDTH        = 1,
    parameter int unsigned MAX_BURST       = 16,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_done,
    output logic                  ap_idle,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [31:0]           size,
    input  logic [31:0]           times,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
`ifdef AXIMM_BURST_WR_CTRL_BRESP_CHECK_EN
    output logic                  err,
`endif
    aximm_burst_wr_ctrl_if.master m_axi_mm_video
);
    localparam int unsigned DATA_BYTES = DATA_WIDTH / 8;
    localparam int unsigned BYTES_LOG2 = data_bytes_log2(DATA_WIDTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_addr_q, base_addr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           beats_q, beats_d;
    logic [31:0]           beats_left_q, beats_left_d;
    logic [31:0]           passes_left_q, passes_left_d;
    logic [8:0]            burst_cnt_q, burst_cnt_d;
    logic [3:0]            outstanding_q, outstanding_d;
    logic                  ap_done_q, ap_done_d;
    logic                  aw_valid_q, aw_valid_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [7:0]            aw_len_q, aw_len_d;
    logic [2:0]            aw_size_q, aw_size_d;
    logic [1:0]            aw_burst_q, aw_burst_d;
    logic [7:0]            calc_len;
    logic                  aw_hs, w_hs, b_hs;

    assign aw_hs = aw_valid_q & m_axi_mm_video.aw_ready;
    assign w_hs  = m_axi_mm_video.w_valid & m_axi_mm_video.w_ready;
    assign b_hs  = m_axi_mm_video.b_valid & m_axi_mm_video.b_ready;

    // Sized from next-state values so AWVALID can rise the cycle after entering ADDR
    burst_len_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) u_len_calc (
        .remaining (beats_left_d),
        .addr_lo   (addr_d[11:0]),
        .len       (calc_len)
    );

    always_comb begin
        state_d       = state_q;
        base_addr_d   = base_addr_q;
        addr_d        = addr_q;
        beats_d       = beats_q;
        beats_left_d  = beats_left_q;
        passes_left_d = passes_left_q;
        burst_cnt_d   = burst_cnt_q;
        ap_done_d     = 1'b0;
        outstanding_d = outstanding_q + {3'd0, aw_hs} - {3'd0, b_hs};

        case (state_q)
            StIdle: begin
                if (ap_start) begin
                    base_addr_d   = dst_addr;
                    addr_d        = dst_addr;
                    beats_d       = size >> BYTES_LOG2;
                    beats_left_d  = size >> BYTES_LOG2;
                    passes_left_d = times;
                    state_d       = ((beats_d == 32'd0) || (times == 32'd0)) ? StDrain : StAddr;
                end
            end
            StAddr: begin
                if (aw_hs) begin
                    burst_cnt_d = {1'b0, aw_len_q} + 9'd1;
                    state_d     = StData;
                end
            end
            StData: begin
                if (w_hs) begin
                    burst_cnt_d  = burst_cnt_q - 9'd1;
                    beats_left_d = beats_left_q - 32'd1;
                    addr_d       = addr_q + ADDR_WIDTH'(DATA_BYTES);
                    if (burst_cnt_q == 9'd1) begin
                        if (beats_left_q != 32'd1) begin
                            state_d = StAddr;
                        end else if (passes_left_q != 32'd1) begin
                            passes_left_d = passes_left_q - 32'd1;
                            beats_left_d  = beats_q;
                            addr_d        = base_addr_q;
                            state_d       = StAddr;
                        end else begin
                            state_d = StDrain;
                        end
                    end
                end
            end
            StDrain: begin
                // Stay one extra cycle so ap_idle rises only after the ap_done pulse
                if (ap_done_q) begin
                    state_d = StIdle;
                end else if (outstanding_d == 4'd0) begin
                    ap_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        aw_valid_d = aw_valid_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        if (aw_hs) begin
            aw_valid_d = 1'b0;
        end
        if ((state_d == StAddr) && !aw_valid_q &&
            ({28'd0, outstanding_d} < MAX_OUTSTANDING)) begin
            aw_valid_d = 1'b1;
            aw_addr_d  = addr_d;
            aw_len_d   = calc_len;
            aw_size_d  = 3'(BYTES_LOG2);
            aw_burst_d = AXI_BURST_INCR;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q       <= StIdle;
            base_addr_q   <= '0;
            addr_q        <= '0;
            beats_q       <= '0;
            beats_left_q  <= '0;
            passes_left_q <= '0;
            burst_cnt_q   <= '0;
            outstanding_q <= '0;
            ap_done_q     <= 1'b0;
            aw_valid_q    <= 1'b0;
            aw_addr_q     <= '0;
            aw_len_q      <= '0;
            aw_size_q     <= '0;
            aw_burst_q    <= '0;
        end else begin
            state_q       <= state_d;
            base_addr_q   <= base_addr_d;
            addr_q        <= addr_d;
            beats_q       <= beats_d;
            beats_left_q  <= beats_left_d;
            passes_left_q <= passes_left_d;
            burst_cnt_q   <= burst_cnt_d;
            outstanding_q <= outstanding_d;
            ap_done_q     <= ap_done_d;
            aw_valid_q    <= aw_valid_d;
            aw_addr_q     <= aw_addr_d;
            aw_len_q      <= aw_len_d;
            aw_size_q     <= aw_size_d;
            aw_burst_q    <= aw_burst_d;
        end
    end

`ifdef AXIMM_BURST_WR_CTRL_BRESP_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (ap_ready) begin
            err_d = 1'b0;
        end
        if (b_hs && (m_axi_mm_video.b_resp != AXI_RESP_OKAY)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign ap_ready = (state_q == StIdle) && ap_start;
    assign ap_idle  = (state_q == StIdle);
    assign ap_done  = ap_done_q;

    assign m_axi_mm_video.aw_valid = aw_valid_q;
    assign m_axi_mm_video.aw_addr  = aw_addr_q;
    assign m_axi_mm_video.aw_id    = '0;
    assign m_axi_mm_video.aw_len   = aw_len_q;
    assign m_axi_mm_video.aw_size  = aw_size_q;
    assign m_axi_mm_video.aw_burst = aw_burst_q;

    // FWFT head word is held until popped, so WVALID cannot drop without a handshake
    assign m_axi_mm_video.w_valid = (state_q == StData) && !fifo_empty;
    assign m_axi_mm_video.w_data  = fifo_rd_data;
    assign m_axi_mm_video.w_strb  = '1;
    assign m_axi_mm_video.w_last  = (state_q == StData) && (burst_cnt_q == 9'd1);
    assign fifo_rd_en             = m_axi_mm_video.w_valid & m_axi_mm_video.w_ready;

    assign m_axi_mm_video.b_ready = !ap_rst;
endmodule

// File: tb/tb_aximm_burst_wr_ctrl.sv
// Randomized self-checking bench for aximm_burst_wr_ctrl. A behavioural model splits each job
// into the expected bursts by address arithmetic; a slave/FIFO model drives random stalls and
// checks every AW, W and B event plus the ap_ctrl timing against it.
// Define AXIMM_BURST_WR_CTRL_BRESP_CHECK_EN to also exercise the err output.
module tb_aximm_burst_wr_ctrl;
    localparam int unsigned AW      = 64;
    localparam int unsigned DW      = 8;
    localparam int unsigned BYTES   = DW / 8;
    localparam int unsigned MAXB    = 16;
    localparam int unsigned MAX_OUT = 2;
    localparam int unsigned NONE    = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          ap_rst, ap_start, ap_ready, ap_done, ap_idle;
    logic [AW-1:0] dst_addr;
    logic [31:0]   size_in, times_in;
    logic          fifo_rd_en, fifo_empty;
    logic [DW-1:0] fifo_rd_data;
`ifdef AXIMM_BURST_WR_CTRL_BRESP_CHECK_EN
    logic          err;
`endif

    always #5 clk = ~clk;

    aximm_burst_wr_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(1)) bus ();

    aximm_burst_wr_ctrl #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .ID_WIDTH        (1),
        .MAX_BURST       (MAXB),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .ap_clk         (clk),
        .ap_rst         (ap_rst),
        .ap_start       (ap_start),
        .ap_ready       (ap_ready),
        .ap_done        (ap_done),
        .ap_idle        (ap_idle),
        .dst_addr       (dst_addr),
        .size           (size_in),
        .times          (times_in),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_rd_data   (fifo_rd_data),
        .fifo_empty     (fifo_empty),
`ifdef AXIMM_BURST_WR_CTRL_BRESP_CHECK_EN
        .err            (err),
`endif
        .m_axi_mm_video (bus)
    );

    int unsigned     n_tests = 0;
    int unsigned     n_fail  = 0;
    longint unsigned cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [AW-1:0]   exp_addr_q[$];
    int unsigned     exp_len_q[$];
    int unsigned     w_len_q[$];
    logic [DW-1:0]   fifo_q[$];
    int unsigned     beat_idx, pops, aw_cnt, pend_b, outst, stall_cnt, stall_at;
    int unsigned     p_rdy, p_bv, p_emp;
    int              b_count, bad_b_idx;
    longint unsigned last_b_cyc;
    bit              slave_en;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void clear_model();
        exp_addr_q.delete();
        exp_len_q.delete();
        w_len_q.delete();
        fifo_q.delete();
        beat_idx  = 0;
        pops      = 0;
        aw_cnt    = 0;
        pend_b    = 0;
        outst     = 0;
        stall_cnt = 0;
        stall_at  = NONE;
    endfunction

    // Expected burst list: each pass walks the region from the base, cutting bursts at
    // MAXB beats and at every 4 KB boundary.
    function automatic void build_bursts(input logic [AW-1:0] a0, input int unsigned nbeats,
                                         input int unsigned ntimes);
        logic [AW-1:0] a;
        int unsigned   rem, room, n;
        for (int p = 0; p < int'(ntimes); p++) begin
            a   = a0;
            rem = nbeats;
            while (rem > 0) begin
                room = (4096 - int'(a % 4096)) / BYTES;
                n    = rem;
                if (n > MAXB) n = MAXB;
                if (n > room) n = room;
                exp_addr_q.push_back(a);
                exp_len_q.push_back(n - 1);
                a   = a + AW'(n * BYTES);
                rem = rem - n;
            end
        end
    endfunction

    // Slave + FIFO model: drive at the falling edge, judge handshakes 1 ns later
    initial begin
        forever begin
            @(negedge clk);
            if (!slave_en) begin
                bus.aw_ready = 1'b0;
                bus.w_ready  = 1'b0;
                bus.b_valid  = 1'b0;
                fifo_empty   = 1'b1;
            end else begin
                bus.aw_ready = ($urandom_range(0, 99) < p_rdy);
                bus.w_ready  = ($urandom_range(0, 99) < p_rdy);
                if (stall_cnt > 0) begin
                    fifo_empty = 1'b1;
                    stall_cnt--;
                end else begin
                    fifo_empty = (fifo_q.size() == 0) || ($urandom_range(0, 99) < p_emp);
                end
                fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
                bus.b_valid  = (pend_b > 0) && ($urandom_range(0, 99) < p_bv);
                bus.b_resp   = (bus.b_valid && (b_count == bad_b_idx)) ? 2'b10 : 2'b00;
                #1;
                if (fifo_empty) check("wvalid_while_empty", bus.w_valid, 1'b0);
                if (bus.aw_valid && bus.aw_ready) begin
                    aw_cnt++;
                    check("aw_expected", exp_addr_q.size() > 0, 1'b1);
                    if (exp_addr_q.size() > 0) begin
                        check("aw_addr", bus.aw_addr, exp_addr_q.pop_front());
                        w_len_q.push_back(exp_len_q.pop_front());
                        check("aw_len", bus.aw_len, w_len_q[w_len_q.size()-1]);
                    end
                    check("aw_size", bus.aw_size, 3'd0);
                    check("aw_burst", bus.aw_burst, 2'b01);
                    check("aw_id", bus.aw_id, 1'b0);
                    outst++;
                end
                if (bus.w_valid && bus.w_ready) begin
                    check("w_in_burst", w_len_q.size() > 0, 1'b1);
                    check("fifo_rd_en_hs", fifo_rd_en, 1'b1);
                    check("w_strb", bus.w_strb, 1'b1);
                    if (fifo_q.size() > 0) check("w_data", bus.w_data, fifo_q.pop_front());
                    if (w_len_q.size() > 0) begin
                        check("w_last", bus.w_last, beat_idx == w_len_q[0]);
                        if (beat_idx == w_len_q[0]) begin
                            beat_idx = 0;
                            void'(w_len_q.pop_front());
                            pend_b++;
                        end else begin
                            beat_idx++;
                        end
                    end
                    pops++;
                    if (pops == stall_at) begin
                        stall_cnt = 10;
                        stall_at  = NONE;
                    end
                end else begin
                    check("fifo_rd_en_idle", fifo_rd_en, 1'b0);
                end
                if (bus.b_valid && bus.b_ready) begin
                    pend_b--;
                    outst--;
                    b_count++;
                    last_b_cyc = cyc;
                end
                check("outstanding_limit", outst <= MAX_OUT, 1'b1);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_awvalid"}, bus.aw_valid, 1'b0);
        check({tag, "_wvalid"}, bus.w_valid, 1'b0);
        check({tag, "_wlast"}, bus.w_last, 1'b0);
        check({tag, "_rd_en"}, fifo_rd_en, 1'b0);
        check({tag, "_ready"}, ap_ready, 1'b0);
        check({tag, "_done"}, ap_done, 1'b0);
        check({tag, "_idle"}, ap_idle, 1'b1);
        check({tag, "_awaddr"}, bus.aw_addr, 64'd0);
        check({tag, "_awlen"}, bus.aw_len, 8'd0);
        check({tag, "_awsize"}, bus.aw_size, 3'd0);
        check({tag, "_awburst"}, bus.aw_burst, 2'd0);
        check({tag, "_bready"}, bus.b_ready, 1'b0);
`ifdef AXIMM_BURST_WR_CTRL_BRESP_CHECK_EN
        check({tag, "_err"}, err, 1'b0);
`endif
    endtask

    // Loads the model and FIFO, pulses ap_start; returns the ap_ready cycle
    task automatic start_job(input logic [AW-1:0] a, input int unsigned sz,
                             input int unsigned tm, output longint unsigned r_cyc);
        clear_model();
        for (int i = 0; i < int'((sz / BYTES) * tm); i++) fifo_q.push_back(DW'($urandom));
        build_bursts(a, sz / BYTES, tm);
        @(negedge clk);
        dst_addr = a;
        size_in  = sz;
        times_in = tm;
        ap_start = 1'b1;
        #2;
        check("ap_ready_on_start", ap_ready, 1'b1);
        r_cyc = cyc;
        @(negedge clk);
        ap_start = 1'b0;
        #2;
        check("ap_idle_after_start", ap_idle, 1'b0);
`ifdef AXIMM_BURST_WR_CTRL_BRESP_CHECK_EN
        check("err_cleared", err, 1'b0);
`endif
    endtask

    task automatic run_job(input logic [AW-1:0] a, input int unsigned sz, input int unsigned tm,
                           input int unsigned stall_after, input int unsigned rdy,
                           input int unsigned bv, input int unsigned emp, input bit poke);
        longint unsigned r_cyc, done_cyc;
        bit              got_done;
        int              b_start;
        int unsigned     total;
        p_rdy    = rdy;
        p_bv     = bv;
        p_emp    = emp;
        b_start  = b_count;
        total    = (sz / BYTES) * tm;
        got_done = 1'b0;
        done_cyc = 0;
        start_job(a, sz, tm, r_cyc);
        stall_at = stall_after;
        while (!got_done && (cyc - r_cyc) < 4000) begin
            @(negedge clk);
            if (poke && (cyc == r_cyc + 6)) begin
                ap_start = 1'b1;
                dst_addr = {$urandom, $urandom};
                size_in  = $urandom_range(1, 9);
            end else begin
                ap_start = 1'b0;
            end
            #2;
            if (ap_start) check("start_ignored_busy", ap_ready, 1'b0);
            if (ap_done) begin
                got_done = 1'b1;
                done_cyc = cyc;
            end
        end
        ap_start = 1'b0;
        check("done_seen", got_done, 1'b1);
        if (total == 0) begin
            check("zero_done_latency", done_cyc - r_cyc, 64'd2);
            check("zero_no_aw", aw_cnt, 0);
            check("zero_no_w", pops, 0);
        end else begin
            check("done_after_last_b", done_cyc - last_b_cyc, 64'd1);
            check("pop_count", pops, total);
            check("bursts_left", exp_addr_q.size(), 0);
            check("b_pending", pend_b, 0);
        end
        check("idle_during_done", ap_idle, 1'b0);
`ifdef AXIMM_BURST_WR_CTRL_BRESP_CHECK_EN
        check("err_at_done", err, (bad_b_idx >= b_start) && (bad_b_idx < b_count));
`endif
        @(negedge clk);
        #2;
        check("done_pulse_one_cycle", ap_done, 1'b0);
        check("idle_after_done", ap_idle, 1'b1);
    endtask

    task automatic reset_mid_burst();
        longint unsigned r_cyc;
        p_rdy = 100;
        p_bv  = 50;
        p_emp = 0;
        start_job(64'h7F0, 64, 2, r_cyc);
        while (pops < 5 && (cyc - r_cyc) < 1000) @(negedge clk);
        check("reached_mid_burst", pops >= 5, 1'b1);
        @(negedge clk);
        slave_en     = 1'b0;
        ap_rst       = 1'b1;
        bus.aw_ready = 1'b0;
        bus.w_ready  = 1'b0;
        bus.b_valid  = 1'b0;
        fifo_empty   = 1'b1;
        @(negedge clk);
        #2;
        check_reset_values("mid_rst");
        @(negedge clk);
        ap_rst = 1'b0;
        clear_model();
        slave_en = 1'b1;
        @(negedge clk);
        #2;
        check("bready_after_rst", bus.b_ready, 1'b1);
        check("idle_after_rst", ap_idle, 1'b1);
    endtask

    initial begin
        logic [AW-1:0] ra;
        ap_rst       = 1'b1;
        ap_start     = 1'b0;
        dst_addr     = '0;
        size_in      = '0;
        times_in     = '0;
        fifo_empty   = 1'b1;
        fifo_rd_data = '0;
        bus.aw_ready = 1'b0;
        bus.w_ready  = 1'b0;
        bus.b_valid  = 1'b0;
        bus.b_resp   = 2'b00;
        bus.b_id     = 1'b0;
        slave_en     = 1'b0;
        b_count      = 0;
        bad_b_idx    = -1;
        last_b_cyc   = 0;
        clear_model();
        p_rdy = 100;
        p_bv  = 100;
        p_emp = 0;

        repeat (3) @(negedge clk);
        #2;
        check_reset_values("por");
        @(negedge clk);
        ap_rst   = 1'b0;
        slave_en = 1'b1;
        @(negedge clk);
        #2;
        check("bready_out_of_rst", bus.b_ready, 1'b1);

        run_job(64'h1000, 40, 1, NONE, 100, 100, 0, 1'b0);
        run_job(64'h0FF8, 32, 1, NONE, 100, 100, 0, 1'b0);
        run_job(64'h2000, 16, 3, NONE, 60, 30, 20, 1'b1);
        run_job(64'h3000, 0, 5, NONE, 100, 100, 0, 1'b0);
        run_job(64'h3000, 10, 0, NONE, 100, 100, 0, 1'b0);
        run_job(64'h0300, 24, 1, 5, 100, 100, 0, 1'b0);

`ifdef AXIMM_BURST_WR_CTRL_BRESP_CHECK_EN
        bad_b_idx = b_count + 1;
        run_job(64'h4000, 48, 1, NONE, 100, 100, 0, 1'b0);
        bad_b_idx = -1;
        run_job(64'h4000, 8, 1, NONE, 100, 100, 0, 1'b0);
`endif

        reset_mid_burst();

        for (int j = 0; j < 12; j++) begin
            ra = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) ra[11:0] = 12'(4096 - $urandom_range(1, 40));
            run_job(ra, $urandom_range(1, 70), $urandom_range(1, 3),
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : NONE,
                    $urandom_range(40, 100), $urandom_range(20, 100),
                    $urandom_range(0, 30), j[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
